vga_rect_engine: RTL and testbench

Hardware rectangle draw engine; the writer side of the 80x60 VGA framebuffer, which the VGA scan logic reads. It accepts a rectangle command from the RAT MCU (corners, colour, fill/outline mode) and emits one framebuffer write per cycle on a WA/WD/WE port. That port is muxed into the framebuffer write port alongside MCU writes. MCU writes take priority through STALL.

---
 rtl/vga_fb_pkg.sv | 28 ++
 rtl/vga_rect_engine_if.sv | 32 +++
 rtl/vga_rect_cursor.sv | 54 +++++
 rtl/vga_rect_engine.sv | 103 ++++++++++
 tb/tb_vga_rect_engine.sv | 206 ++++++++++++++++++++
 5 files changed

// File: rtl/vga_fb_pkg.sv
// Shared constants, state encoding and address helper for the
// 80x60 framebuffer writer path.
package vga_fb_pkg;

   localparam int COLS  = 80;
   localparam int ROWS  = 60;
   localparam int XW    = 7;
   localparam int YW    = 6;
   localparam int FB_AW = XW + YW;

   localparam logic [XW-1:0] X_MAX = XW'(COLS - 1);
   localparam logic [YW-1:0] Y_MAX = YW'(ROWS - 1);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SETUP = 2'd1,
      ST_DRAW  = 2'd2,
      ST_DONE  = 2'd3
   } state_t;

   function automatic logic [FB_AW-1:0] fb_addr(
      input logic [YW-1:0] y,
      input logic [XW-1:0] x
   );
      return {y, x};
   endfunction

endpackage

// File: rtl/vga_rect_engine_if.sv
// Command and framebuffer write port bundle of the rectangle engine.
// master = MCU/bench side, slave = engine side.
interface vga_rect_engine_if;
   import vga_fb_pkg::*;

   logic             START;
   logic [XW-1:0]    X0;
   logic [YW-1:0]    Y0;
   logic [XW-1:0]    X1;
   logic [YW-1:0]    Y1;
   logic [7:0]       COLOR;
   logic             OUTLINE;
   logic             STALL;
   logic [FB_AW-1:0] WA;
   logic [7:0]       WD;
   logic             WE;
   logic             BUSY;
   logic             DONE;

   modport master (
      output START, X0, Y0, X1, Y1,
      output COLOR, OUTLINE, STALL,
      input  WA, WD, WE, BUSY, DONE
   );

   modport slave (
      input  START, X0, Y0, X1, Y1,
      input  COLOR, OUTLINE, STALL,
      output WA, WD, WE, BUSY, DONE
   );

endinterface

// File: rtl/vga_rect_cursor.sv
// Raster cursor over a clipped rectangle; in outline mode interior
// rows visit only the left and right columns.
module vga_rect_cursor
   import vga_fb_pkg::*;
(
   input  logic          i_clk,
   input  logic          i_rst_n,
   input  logic          i_load,
   input  logic          i_step,
   input  logic          i_outline,
   input  logic [XW-1:0] i_xl,
   input  logic [XW-1:0] i_xr,
   input  logic [YW-1:0] i_yt,
   input  logic [YW-1:0] i_yb,
   output logic [XW-1:0] o_x,
   output logic [YW-1:0] o_y,
   output logic          o_last
);

   logic [XW-1:0] r_x;
   logic [YW-1:0] r_y;
   logic          w_row_end;
   logic          w_edge_row;
   logic          w_jump;

   assign w_row_end  = (r_x == i_xr);
   assign w_edge_row = (r_y == i_yt) || (r_y == i_yb);
   // row end wins so a one-column outline still steps down
   assign w_jump     = i_outline && !w_edge_row &&
                       (r_x == i_xl) && !w_row_end;
   assign o_last     = w_row_end && (r_y == i_yb);
   assign o_x        = r_x;
   assign o_y        = r_y;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_x <= '0;
         r_y <= '0;
      end else if (i_load) begin
         r_x <= i_xl;
         r_y <= i_yt;
      end else if (i_step) begin
         unique case (1'b1)
            w_row_end: begin
               r_x <= i_xl;
               r_y <= r_y + 1'b1;
            end
            w_jump:  r_x <= i_xr;
            default: r_x <= r_x + 1'b1;
         endcase
      end
   end

endmodule

// File: rtl/vga_rect_engine.sv
// Rectangle draw engine: captures a command, clips/sorts corners and
// emits one framebuffer write per unstalled cycle.
module vga_rect_engine
   import vga_fb_pkg::*;
(
   input  logic               CLK,
   input  logic               RST_N,
   vga_rect_engine_if.slave   bus
);

   state_t        r_state;
   logic [XW-1:0] r_x0;
   logic [XW-1:0] r_x1;
   logic [YW-1:0] r_y0;
   logic [YW-1:0] r_y1;
   logic [7:0]    r_color;
   logic          r_outline;

   logic [XW-1:0] w_cx0;
   logic [XW-1:0] w_cx1;
   logic [YW-1:0] w_cy0;
   logic [YW-1:0] w_cy1;
   logic [XW-1:0] w_xl;
   logic [XW-1:0] w_xr;
   logic [YW-1:0] w_yt;
   logic [YW-1:0] w_yb;
   logic [XW-1:0] w_x;
   logic [YW-1:0] w_y;
   logic          w_last;
   logic          w_we;
   logic          w_load;
   logic          w_step;

   // captured corners stay stable, so clip/sort can stay combinational
   assign w_cx0 = (r_x0 > X_MAX) ? X_MAX : r_x0;
   assign w_cx1 = (r_x1 > X_MAX) ? X_MAX : r_x1;
   assign w_cy0 = (r_y0 > Y_MAX) ? Y_MAX : r_y0;
   assign w_cy1 = (r_y1 > Y_MAX) ? Y_MAX : r_y1;

   assign w_xl = (w_cx0 < w_cx1) ? w_cx0 : w_cx1;
   assign w_xr = (w_cx0 < w_cx1) ? w_cx1 : w_cx0;
   assign w_yt = (w_cy0 < w_cy1) ? w_cy0 : w_cy1;
   assign w_yb = (w_cy0 < w_cy1) ? w_cy1 : w_cy0;

   assign w_load = (r_state == ST_SETUP);
   assign w_we   = (r_state == ST_DRAW) && !bus.STALL;
   assign w_step = w_we && !w_last;

   vga_rect_cursor u_cursor (
      .i_clk     (CLK),
      .i_rst_n   (RST_N),
      .i_load    (w_load),
      .i_step    (w_step),
      .i_outline (r_outline),
      .i_xl      (w_xl),
      .i_xr      (w_xr),
      .i_yt      (w_yt),
      .i_yb      (w_yb),
      .o_x       (w_x),
      .o_y       (w_y),
      .o_last    (w_last)
   );

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         r_state   <= ST_IDLE;
         r_x0      <= '0;
         r_x1      <= '0;
         r_y0      <= '0;
         r_y1      <= '0;
         r_color   <= '0;
         r_outline <= 1'b0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (bus.START) begin
                  r_x0      <= bus.X0;
                  r_x1      <= bus.X1;
                  r_y0      <= bus.Y0;
                  r_y1      <= bus.Y1;
                  r_color   <= bus.COLOR;
                  r_outline <= bus.OUTLINE;
                  r_state   <= ST_SETUP;
               end
            end
            ST_SETUP: r_state <= ST_DRAW;
            ST_DRAW: begin
               if (w_we && w_last) r_state <= ST_DONE;
            end
            ST_DONE: r_state <= ST_IDLE;
            default: r_state <= ST_IDLE;
         endcase
      end
   end

   assign bus.WE   = w_we;
   assign bus.WA   = w_we ? fb_addr(w_y, w_x) : '0;
   assign bus.WD   = w_we ? r_color : '0;
   assign bus.BUSY = (r_state == ST_SETUP) ||
                     (r_state == ST_DRAW);
   assign bus.DONE = (r_state == ST_DONE);

endmodule

// File: tb/tb_vga_rect_engine.sv
// Directed, table-driven bench for vga_rect_engine: write sequences,
// latency, stall, ignored START and asynchronous reset abort.
module tb_vga_rect_engine;
   import vga_fb_pkg::*;

   typedef struct packed {
      logic [6:0]        x0;
      logic [5:0]        y0;
      logic [6:0]        x1;
      logic [5:0]        y1;
      logic [7:0]        color;
      logic              outline;
      logic [4:0]        n;
      logic [3:0]        st_at;
      logic [1:0]        st_len;
      logic              mid;
      logic [0:15][12:0] wa;
   } vec_t;

   logic CLK;
   logic RST_N;
   int   checks;
   int   errors;
   vec_t v [10];

   vga_rect_engine_if bus ();

   vga_rect_engine dut (
      .CLK   (CLK),
      .RST_N (RST_N),
      .bus   (bus)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   task automatic chk(input string nm,
                      input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   function automatic vec_t mk(
      input logic [6:0] x0, input logic [5:0] y0,
      input logic [6:0] x1, input logic [5:0] y1,
      input logic [7:0] c, input logic o,
      input logic [4:0] n, input logic [3:0] sa,
      input logic [1:0] sl, input logic m);
      vec_t r;
      r = '0;
      r.x0 = x0; r.y0 = y0; r.x1 = x1; r.y1 = y1;
      r.color = c; r.outline = o; r.n = n;
      r.st_at = sa; r.st_len = sl; r.mid = m;
      return r;
   endfunction

   task automatic run_vec(input int id, input vec_t t);
      int  cyc;
      int  n;
      int  done_cyc;
      bit  got;
      bit  stl;
      @(negedge CLK);
      bus.X0 = t.x0; bus.Y0 = t.y0;
      bus.X1 = t.x1; bus.Y1 = t.y1;
      bus.COLOR = t.color; bus.OUTLINE = t.outline;
      bus.START = 1'b1;
      @(negedge CLK);
      bus.START = 1'b0;
      cyc = 1;
      chk($sformatf("v%0d setup_busy", id), 32'(bus.BUSY), 1);
      chk($sformatf("v%0d setup_we", id), 32'(bus.WE), 0);
      n = 0; got = 0; done_cyc = 0;
      while (!got && cyc < 200) begin
         bus.STALL = (t.st_len != 0) && (cyc + 1 >= t.st_at) &&
                     (cyc + 1 < t.st_at + t.st_len);
         bus.START = t.mid && (cyc + 1 == 4);
         if (bus.START) begin
            bus.X0 = 7'd0; bus.Y0 = 6'd0;
            bus.X1 = 7'd70; bus.Y1 = 6'd50;
            bus.COLOR = ~t.color; bus.OUTLINE = 1'b0;
         end
         @(negedge CLK);
         cyc++;
         stl = bus.STALL;
         if (stl) chk($sformatf("v%0d stall_we", id),
                      32'(bus.WE), 0);
         if (bus.WE) begin
            if (n == 0)
               chk($sformatf("v%0d first_cyc", id), cyc, 2);
            if (n < int'(t.n)) begin
               chk($sformatf("v%0d wa%0d", id, n),
                   32'(bus.WA), 32'(t.wa[n]));
               chk($sformatf("v%0d wd%0d", id, n),
                   32'(bus.WD), 32'(t.color));
            end
            n++;
         end else begin
            chk($sformatf("v%0d wa_idle", id), 32'(bus.WA), 0);
         end
         if (bus.DONE) begin
            got = 1;
            done_cyc = cyc;
            chk($sformatf("v%0d done_busy", id),
                32'(bus.BUSY), 0);
         end else begin
            chk($sformatf("v%0d draw_busy", id),
                32'(bus.BUSY), 1);
         end
      end
      bus.START = 1'b0;
      bus.STALL = 1'b0;
      chk($sformatf("v%0d got_done", id), 32'(got), 1);
      chk($sformatf("v%0d count", id), n, int'(t.n));
      chk($sformatf("v%0d done_cyc", id), done_cyc,
          2 + int'(t.n) + int'(t.st_len));
      @(negedge CLK);
      chk($sformatf("v%0d post_done", id), 32'(bus.DONE), 0);
      chk($sformatf("v%0d post_busy", id), 32'(bus.BUSY), 0);
      chk($sformatf("v%0d post_we", id), 32'(bus.WE), 0);
   endtask

   initial begin
      checks = 0;
      errors = 0;
      RST_N = 1'b0;
      bus.START = 1'b0; bus.STALL = 1'b0;
      bus.X0 = '0; bus.Y0 = '0; bus.X1 = '0; bus.Y1 = '0;
      bus.COLOR = '0; bus.OUTLINE = 1'b0;

      v[0] = mk(3, 4, 4, 5, 8'hE0, 0, 4, 0, 0, 0);
      v[0].wa[0:3] = {13'h203, 13'h204, 13'h283, 13'h284};
      v[1] = mk(4, 5, 3, 4, 8'h1C, 0, 4, 0, 0, 0);
      v[1].wa[0:3] = {13'h203, 13'h204, 13'h283, 13'h284};
      v[2] = mk(78, 58, 100, 63, 8'hFF, 0, 4, 0, 0, 0);
      v[2].wa[0:3] = {13'h1D4E, 13'h1D4F, 13'h1DCE, 13'h1DCF};
      v[3] = mk(0, 0, 3, 2, 8'h03, 1, 10, 0, 0, 1);
      v[3].wa[0:4] = {13'h000, 13'h001, 13'h002, 13'h003,
                      13'h080};
      v[3].wa[5:9] = {13'h083, 13'h100, 13'h101, 13'h102,
                      13'h103};
      v[4] = mk(10, 10, 10, 10, 8'h55, 1, 1, 0, 0, 0);
      v[4].wa[0] = 13'h50A;
      v[5] = mk(5, 3, 5, 0, 8'h92, 1, 4, 0, 0, 0);
      v[5].wa[0:3] = {13'h005, 13'h085, 13'h105, 13'h185};
      v[6] = mk(0, 0, 1, 2, 8'h49, 1, 6, 0, 0, 0);
      v[6].wa[0:5] = {13'h000, 13'h001, 13'h080, 13'h081,
                      13'h100, 13'h101};
      v[7] = mk(1, 1, 4, 4, 8'hB6, 1, 12, 0, 0, 0);
      v[7].wa[0:5] = {13'h081, 13'h082, 13'h083, 13'h084,
                      13'h101, 13'h104};
      v[7].wa[6:11] = {13'h181, 13'h184, 13'h201, 13'h202,
                       13'h203, 13'h204};
      v[8] = mk(1, 1, 3, 3, 8'h6D, 0, 9, 0, 0, 0);
      v[8].wa[0:4] = {13'h081, 13'h082, 13'h083, 13'h101,
                      13'h102};
      v[8].wa[5:8] = {13'h103, 13'h181, 13'h182, 13'h183};
      v[9] = mk(3, 4, 4, 5, 8'hE0, 0, 4, 3, 3, 1);
      v[9].wa[0:3] = {13'h203, 13'h204, 13'h283, 13'h284};

      #7;
      chk("rst_we", 32'(bus.WE), 0);
      chk("rst_busy", 32'(bus.BUSY), 0);
      chk("rst_done", 32'(bus.DONE), 0);
      chk("rst_wa", 32'(bus.WA), 0);
      chk("rst_wd", 32'(bus.WD), 0);
      @(negedge CLK);
      RST_N = 1'b1;

      for (int i = 0; i < 10; i++) run_vec(i, v[i]);

      @(negedge CLK);
      bus.X0 = 0; bus.Y0 = 0; bus.X1 = 9; bus.Y1 = 9;
      bus.COLOR = 8'hAA; bus.OUTLINE = 1'b0;
      bus.START = 1'b1;
      @(negedge CLK);
      bus.START = 1'b0;
      repeat (4) @(negedge CLK);
      chk("pre_rst_we", 32'(bus.WE), 1);
      #2 RST_N = 1'b0;
      #1;
      chk("abort_we", 32'(bus.WE), 0);
      chk("abort_busy", 32'(bus.BUSY), 0);
      chk("abort_done", 32'(bus.DONE), 0);
      chk("abort_wa", 32'(bus.WA), 0);
      @(negedge CLK);
      chk("held_we", 32'(bus.WE), 0);
      RST_N = 1'b1;
      for (int k = 0; k < 3; k++) begin
         @(negedge CLK);
         chk("idle_we", 32'(bus.WE), 0);
         chk("idle_busy", 32'(bus.BUSY), 0);
         chk("idle_done", 32'(bus.DONE), 0);
      end
      run_vec(10, v[0]);

      $display("Simulation finished: %0d checks, %0d errors",
               checks, errors);
      $finish;
   end

endmodule
